alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Parametrised, registered integer execution unit for the out-of-order core's ALU issue port.
- Accepts one micro-op per cycle from the reservation station over a valid/ready handshake.
- Carries the ROB tag through and presents a registered result, Zero flag and illegal-op flag to the CDB arbiter.
- Extends the single-cycle ALU op set with AND, logical shifts and compares, adds flush, and optionally adds an iterative multiplier.

Parameters:
- XLEN, 32, operand/result width; power of two, at least 8.
- TAG_W, 6, ROB tag width.
- SHAMT_W, $clog2(XLEN), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline squash (mispredict/exception).
- in_valid  in  1  issue request.
- in_ready  out  1  unit can accept the op this cycle.
- in_op  in  4  ALU control code.
- in_a  in  XLEN  operand 1.
- in_b  in  XLEN  operand 2 (rs2 or immediate).
- in_tag  in  TAG_W  ROB tag.
- out_valid  out  1  result held.
- out_ready  in  1  CDB accepted result.
- out_result  out  XLEN  result.
- out_zero  out  1  out_result == 0.
- out_illegal  out  1  op code unsupported.
- out_tag  out  TAG_W  ROB tag of result.

Behaviour:
- Op codes:
  - 0010 ADD, 0110 SUB, 0001 OR, 0011 XOR, 0000 AND.
  - 0111 SRA, 0100 SLL, 0101 SRL; shift amount is in_b[SHAMT_W-1:0].
  - 1000 PASSB.
  - 1001 SLT (signed) and 1010 SLTU; result is 1 or 0, zero-extended.
  - All add/sub arithmetic is modulo 2^XLEN.
- Unsupported codes give result 0 and out_illegal=1. The op still completes normally, and out_zero=1 for it.
- Reset (rst_n low, asynchronous): out_valid=0, out_result=0, out_tag=0, out_zero=1, out_illegal=0, internal FSM=IDLE.
- Handshake:
  - Transfer in: in_valid && in_ready at a clock edge.
  - Transfer out: out_valid && out_ready at a clock edge.
  - in_ready = !flush && fsm==IDLE && (!out_valid || out_ready). This is combinational, so throughput is 1 op/cycle under continuous out_ready.
- Latency: single-cycle ops appear on out_* in the cycle after acceptance.
- Output hold: out_* is stable while out_valid && !out_ready.
- Flush:
  - On any edge with flush=1, out_valid is cleared and the FSM returns to IDLE.
  - No input is accepted that cycle (in_ready=0).
  - flush has priority over every other event.
- Simultaneous out transfer and in transfer: the new result replaces the old one; out_valid stays 1.
- Reset mid-operation: all state is discarded immediately.
- out_zero and out_illegal are registered together with out_result.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - Op 1100 MUL gives the low XLEN bits of a*b, computed by a radix-2 shift-add in XLEN cycles.
  - FSM states IDLE -> MUL_BUSY -> IDLE. The accept edge loads the multiplicand, multiplier, accumulator, tag and count. Each busy cycle is one add/shift step.
  - After the final step, the FSM returns to IDLE and the result is written with out_valid=1 at the next edge, provided the output register is free (!out_valid || out_ready). Otherwise it stays in MUL_BUSY holding the result.
  - Latency from acceptance to out_valid is XLEN+1 cycles.
  - in_ready=0 while in MUL_BUSY.
  - flush aborts the multiply.
- Undefined: 1100 is illegal, the FSM is IDLE-only, and no multiplier logic is built.

Decomposition:
- Package alu_pkg holds:
  - op-code localparams (ALU_ADD, ALU_SUB, ALU_OR, ALU_XOR, ALU_AND, ALU_SRA, ALU_SLL, ALU_SRL, ALU_PASSB, ALU_SLT, ALU_SLTU, ALU_MUL);
  - the FSM state enum;
  - the function alu_is_legal(op).
- Sub-module alu_comb_core (parametrised by XLEN) holds the pure combinational op/result/illegal logic. The top module holds the handshake, output register and mul FSM.

Test Plan:
1. Reset then ADD a=0xFFFFFFFF, b=1, tag=5 -> next cycle out_valid=1, result=0, out_zero=1, out_tag=5.
2. SRA a=0x80000000, b=0x24 (shamt 4) -> 0xF8000000. SRL on the same operands -> 0x08000000. SLT a=-1, b=1 -> 1. SLTU on the same operands -> 0.
3. Back-to-back ops with out_ready held low on the 2nd: first result stable and in_ready=0 until out_ready=1. Then a 1 op/cycle stream with no drops or duplicates across 8 ops.
4. Op 1111 -> result 0, out_illegal=1, out_zero=1. A following legal SUB 7-9 -> 0xFFFFFFFE, illegal=0.
5. flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the op is not accepted. Also assert rst_n low mid-stream -> outputs return to reset values asynchronously.
6. With ALU_MUL_EN: MUL 0x0001_0003 * 7 -> 0x0007_0015 exactly 33 cycles after acceptance, in_ready=0 throughout. Flush at cycle 10 -> no result, in_ready=1 the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU execution unit:
//   - 4-bit ALU op-code constants
//   - state type for the multiply sequencer
//   - alu_is_legal(): true for every op code the build supports
// Build option: define ALU_MUL_EN to make op ALU_MUL (1100) legal and to build
// the iterative multiplier in alu_exec_unit.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1000;
  localparam logic [3:0] ALU_SLT   = 4'b1001;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;
  localparam logic [3:0] ALU_MUL   = 4'b1100;

`ifdef ALU_MUL_EN
  localparam logic ALU_MUL_BUILT = 1'b1;
`else
  localparam logic ALU_MUL_BUILT = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } alu_state_e;

  // Op-code legality for the current build; MUL is legal only with the multiplier.
  function automatic logic alu_is_legal(input logic [3:0] op);
    logic legal_s;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL,
      ALU_SUB, ALU_SRA, ALU_PASSB, ALU_SLT, ALU_SLTU: legal_s = 1'b1;
      ALU_MUL: legal_s = ALU_MUL_BUILT;
      default: legal_s = 1'b0;
    endcase
    return legal_s;
  endfunction

endpackage

// File: rtl/alu_exec_unit_comb_core.sv
// -----------------------------------------------------------------------------
// alu_comb_core
// Purely combinational single-cycle ALU datapath.
// Ports:
//   op_i       4-bit ALU op code
//   a_i, b_i   XLEN-bit operands (shift amount taken from b_i[SHAMT_W-1:0])
//   result_o   XLEN-bit result (0 for unsupported codes and for MUL)
//   illegal_o  op code not supported by this build
// -----------------------------------------------------------------------------
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            illegal_o
);

  localparam int SHAMT_W = $clog2(XLEN);

  logic [SHAMT_W-1:0] shamt_s;
  logic               slt_s;
  logic               sltu_s;

  assign shamt_s = b_i[SHAMT_W-1:0];
  assign slt_s   = ($signed(a_i) < $signed(b_i));
  assign sltu_s  = (a_i < b_i);

  // Result select; MUL is produced by the sequencer in the top, so it yields 0 here.
  always_comb begin
    result_o = {XLEN{1'b0}};
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_SRA:   result_o = XLEN'($signed(a_i) >>> shamt_s);
      ALU_SLL:   result_o = a_i << shamt_s;
      ALU_SRL:   result_o = a_i >> shamt_s;
      ALU_PASSB: result_o = b_i;
      ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, slt_s};
      ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, sltu_s};
      default:   result_o = {XLEN{1'b0}};
    endcase
  end

  assign illegal_o = !alu_is_legal(op_i);

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Registered integer execution unit for the ALU issue port.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   flush                      squash: drops the held result and any multiply
//   in_valid/in_ready          issue handshake (in_ready is combinational)
//   in_op, in_a, in_b, in_tag  micro-op, operands and ROB tag
//   out_valid/out_ready        result handshake towards the CDB arbiter
//   out_result, out_zero,      registered result, result==0 flag,
//   out_illegal, out_tag       unsupported-op flag and ROB tag
// Build option: ALU_MUL_EN adds op 1100 (MUL), a radix-2 shift-add multiplier
// taking XLEN+1 cycles from acceptance to out_valid.
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic             out_valid_q,   out_valid_d;
  logic [XLEN-1:0]  out_result_q,  out_result_d;
  logic             out_zero_q,    out_zero_d;
  logic             out_illegal_q, out_illegal_d;
  logic [TAG_W-1:0] out_tag_q,     out_tag_d;

  logic [XLEN-1:0]  core_result_s;
  logic             core_illegal_s;
  logic             out_free_s;
  logic             accept_s;
  logic             mul_start_s;
  logic             mul_done_s;
  logic [XLEN-1:0]  mul_result_s;
  logic [TAG_W-1:0] mul_tag_s;

  alu_comb_core #(
    .XLEN (XLEN)
  ) u_core (
    .op_i      (in_op),
    .a_i       (in_a),
    .b_i       (in_b),
    .result_o  (core_result_s),
    .illegal_o (core_illegal_s)
  );

  // Output register can take a new result if empty or being drained this edge.
  assign out_free_s = !out_valid_q || out_ready;
  assign accept_s   = in_valid && in_ready;

`ifdef ALU_MUL_EN
  localparam int SHAMT_W = $clog2(XLEN);
  localparam int CNT_W   = SHAMT_W + 1;

  alu_state_e       state_q,  state_d;
  logic [XLEN-1:0]  mcand_q,  mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [TAG_W-1:0] mtag_q,   mtag_d;

  assign in_ready     = !flush && (state_q == ST_IDLE) && out_free_s;
  assign mul_start_s  = accept_s && (in_op == ALU_MUL);
  // cnt_q reaching zero means all XLEN steps are done and acc_q is final.
  assign mul_done_s   = (state_q == ST_MUL_BUSY) && (cnt_q == {CNT_W{1'b0}}) && out_free_s;
  assign mul_result_s = acc_q;
  assign mul_tag_s    = mtag_q;

  // Multiply sequencer next state: load on accept, one add/shift step per busy cycle.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mtag_d   = mtag_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mul_start_s) begin
            state_d  = ST_MUL_BUSY;
            mcand_d  = in_a;
            mplier_d = in_b;
            acc_d    = {XLEN{1'b0}};
            cnt_d    = CNT_W'(XLEN);
            mtag_d   = in_tag;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL_BUSY: begin
          if (cnt_q != {CNT_W{1'b0}}) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : {XLEN{1'b0}});
            mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[XLEN-1:1]};
            cnt_d    = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (out_free_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_MUL_BUSY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Multiply sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= {XLEN{1'b0}};
      mplier_q <= {XLEN{1'b0}};
      acc_q    <= {XLEN{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      mtag_q   <= {TAG_W{1'b0}};
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mtag_q   <= mtag_d;
    end
  end
`else
  assign in_ready     = !flush && out_free_s;
  assign mul_start_s  = 1'b0;
  assign mul_done_s   = 1'b0;
  assign mul_result_s = {XLEN{1'b0}};
  assign mul_tag_s    = {TAG_W{1'b0}};
`endif

  // Output register next state; flush wins, then new single-cycle op, then multiply, then drain.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_zero_d    = out_zero_q;
    out_illegal_d = out_illegal_q;
    out_tag_d     = out_tag_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept_s && !mul_start_s) begin
      out_valid_d   = 1'b1;
      out_result_d  = core_result_s;
      out_zero_d    = (core_result_s == {XLEN{1'b0}});
      out_illegal_d = core_illegal_s;
      out_tag_d     = in_tag;
    end else if (mul_done_s) begin
      out_valid_d   = 1'b1;
      out_result_d  = mul_result_s;
      out_zero_d    = (mul_result_s == {XLEN{1'b0}});
      out_illegal_d = 1'b0;
      out_tag_d     = mul_tag_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output registers; zero flag resets to 1 to match the reset result of 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= {XLEN{1'b0}};
      out_zero_q    <= 1'b1;
      out_illegal_q <= 1'b0;
      out_tag_q     <= {TAG_W{1'b0}};
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_zero_q    <= out_zero_d;
      out_illegal_q <= out_illegal_d;
      out_tag_q     <= out_tag_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_zero    = out_zero_q;
  assign out_illegal = out_illegal_q;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed bench for alu_exec_unit (XLEN=32, TAG_W=6) with a cycle-level
// reference model compared against the DUT every cycle, plus literal checks.
// Define ALU_MUL_EN to exercise the multiplier.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic             out_zero;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  alu_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics of the single-cycle op set: {illegal, result}.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        ill;
    ill = 1'b0;
    case (op)
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b0000: r = a & b;
      4'b0111: r = 32'($signed(a) >>> b[4:0]);
      4'b0100: r = a << b[4:0];
      4'b0101: r = a >> b[4:0];
      4'b1000: r = b;
      4'b1001: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1010: r = (a < b) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
    return {ill, r};
  endfunction

  // Reference model state.
  logic             m_valid, m_zero, m_illegal, m_busy;
  logic [31:0]      m_result, m_mres;
  logic [TAG_W-1:0] m_tag, m_mtag;
  int               m_wait;
  logic             exp_ready;
  logic [32:0]      ref_s;

  always_comb begin
    exp_ready = !flush && !m_busy && (!m_valid || out_ready);
    ref_s     = ref_alu(in_op, in_a, in_b);
  end

  // Model update: a multiply result appears XLEN+1 edges after acceptance if the output is free.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_result <= 32'd0; m_zero <= 1'b1; m_illegal <= 1'b0;
      m_tag <= '0; m_busy <= 1'b0; m_wait <= 0; m_mres <= 32'd0; m_mtag <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end else begin
      if (m_valid && out_ready) m_valid <= 1'b0;
      if (in_valid && exp_ready) begin
        if (MUL_EN && in_op == 4'b1100) begin
          m_busy <= 1'b1; m_wait <= XLEN; m_mres <= in_a * in_b; m_mtag <= in_tag;
        end else begin
          m_valid <= 1'b1; m_result <= ref_s[31:0]; m_zero <= (ref_s[31:0] == 32'd0);
          m_illegal <= ref_s[32]; m_tag <= in_tag;
        end
      end else if (m_busy) begin
        if (m_wait != 0) begin
          m_wait <= m_wait - 1;
        end else if (!m_valid || out_ready) begin
          m_valid <= 1'b1; m_result <= m_mres; m_zero <= (m_mres == 32'd0);
          m_illegal <= 1'b0; m_tag <= m_mtag; m_busy <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled between edges.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && chk_en) begin
      check("cyc_in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      check("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
        check("cyc_result", out_result, m_result);
        check("cyc_zero", {31'd0, out_zero}, {31'd0, m_zero});
        check("cyc_illegal", {31'd0, out_illegal}, {31'd0, m_illegal});
        check("cyc_tag", {26'd0, out_tag}, {26'd0, m_tag});
      end
    end
  end

  // Present one op and hold it until the handshake completes; returns at the following negedge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] tag);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    for (int n = 0; n < 60 && !ok; n++) begin
      #1;
      ok = exp_ready;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: op %b never accepted", op);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({pfx, "_result"}, out_result, 32'd0);
    check({pfx, "_zero"}, {31'd0, out_zero}, 32'd1);
    check({pfx, "_illegal"}, {31'd0, out_illegal}, 32'd0);
    check({pfx, "_tag"}, {26'd0, out_tag}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 4'd0;
    in_a = 32'd0; in_b = 32'd0; in_tag = '0; out_ready = 1'b1;
    #12;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: ADD wraps to zero
    send(4'b0010, 32'hFFFF_FFFF, 32'd1, 6'd5);
    #2;
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_result", out_result, 32'd0);
    check("add_zero", {31'd0, out_zero}, 32'd1);
    check("add_tag", {26'd0, out_tag}, 32'd5);

    // 2: shifts and compares
    send(4'b0111, 32'h8000_0000, 32'h24, 6'd6); #2; check("sra", out_result, 32'hF800_0000);
    send(4'b0101, 32'h8000_0000, 32'h24, 6'd7); #2; check("srl", out_result, 32'h0800_0000);
    send(4'b1001, 32'hFFFF_FFFF, 32'd1, 6'd8);  #2; check("slt", out_result, 32'd1);
    send(4'b1010, 32'hFFFF_FFFF, 32'd1, 6'd9);  #2; check("sltu", out_result, 32'd0);
    send(4'b0100, 32'h0000_0003, 32'h21, 6'd10); #2; check("sll", out_result, 32'h0000_0006);
    send(4'b1000, 32'h1234_5678, 32'hCAFE_0001, 6'd11); #2; check("passb", out_result, 32'hCAFE_0001);

    // 3: backpressure then a 1 op/cycle stream
    send(4'b0010, 32'd10, 32'd20, 6'd1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'b0011; in_a = 32'hF0; in_b = 32'hFF; in_tag = 6'd2;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("bp_hold_result", out_result, 32'd30);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #2; check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    check("bp_second_result", out_result, 32'h0F);
    check("bp_second_tag", {26'd0, out_tag}, 32'd2);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_op = 4'b0010; in_a = 32'(k); in_b = 32'd100; in_tag = 6'(k + 20);
      @(negedge clk);
      check("stream_result", out_result, 32'(100 + k));
      check("stream_tag", {26'd0, out_tag}, 32'(k + 20));
    end
    in_valid = 1'b0;

    // 4: illegal op then a legal SUB
    send(4'b1111, 32'd5, 32'd5, 6'd3);
    #2;
    check("ill_result", out_result, 32'd0);
    check("ill_flag", {31'd0, out_illegal}, 32'd1);
    check("ill_zero", {31'd0, out_zero}, 32'd1);
    send(4'b0110, 32'd7, 32'd9, 6'd4);
    #2;
    check("sub_result", out_result, 32'hFFFF_FFFE);
    check("sub_illegal", {31'd0, out_illegal}, 32'd0);
    check("sub_zero", {31'd0, out_zero}, 32'd0);

    // 5: flush with a held result and a pending op
    send(4'b0001, 32'd1, 32'd2, 6'd7);
    out_ready = 1'b0; flush = 1'b1;
    in_valid = 1'b1; in_op = 4'b0010; in_a = 32'd1; in_b = 32'd1; in_tag = 6'd9;
    #2; check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #2; check("flush_valid0", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #2; check("flush_not_taken", {31'd0, out_valid}, 32'd0);

    // 5b: asynchronous reset mid-stream
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'b0010; in_a = 32'd3; in_b = 32'd4; in_tag = 6'd11;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ALU_MUL_EN
    // 6: multiply latency and flush abort
    send(4'b1100, 32'h0001_0003, 32'd7, 6'd12);
    for (int i = 0; i < 33; i++) begin
      #2;
      check("mul_busy_valid", {31'd0, out_valid}, 32'd0);
      check("mul_busy_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    #2;
    check("mul_valid", {31'd0, out_valid}, 32'd1);
    check("mul_result", out_result, 32'h0007_0015);
    check("mul_tag", {26'd0, out_tag}, 32'd12);
    send(4'b1100, 32'd3, 32'd5, 6'd13);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #2;
    check("mulflush_ready", {31'd0, in_ready}, 32'd1);
    check("mulflush_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2; check("mulflush_no_result", {31'd0, out_valid}, 32'd0);
    end
`else
    send(4'b1100, 32'd3, 32'd5, 6'd13);
    #2;
    check("mul_illegal", {31'd0, out_illegal}, 32'd1);
    check("mul_illegal_result", out_result, 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
